imem_fetch_unit: RTL and testbench
==================================

# imem_fetch_unit

Parametrised, loadable instruction memory for the MIPS core's fetch stage. It replaces a fixed, hard-wired program ROM with three features: a synchronous write port for loading programs at bring-up, a pipelined fetch port with configurable latency and a valid handshake, and fault reporting for misaligned or out-of-range fetches. Words never written since reset read back as NOP.

## Interface
- `DATA_W`, 32: instruction word width.
- `ADDR_W`, 32: fetch byte-address width.
- `DEPTH`, 256: number of words. Must be a power of 2, at least 4.
- `LAT`, 1: fetch latency in cycles. Legal range 1..4.
- `NOP_WORD`, 32'h00000000: value returned for unwritten, faulted or flushed fetches.

Ports (`IW` = `$clog2(DEPTH)`):
- `clk`  in  1  clock; everything is sampled on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ld_start`  in  1  enter LOAD from any state; clears the written-map.
- `ld_we`  in  1  write strobe; honoured only in LOAD.
- `ld_addr`  in  IW  word index to write.
- `ld_data`  in  DATA_W  word to write.
- `ld_done`  in  1  leave LOAD and enter RUN.
- `fetch_req`  in  1  fetch request.
- `fetch_addr`  in  ADDR_W  byte address to fetch.
- `fetch_ready`  out  1  high only in RUN; a request is accepted when `fetch_req & fetch_ready`.
- `flush`  in  1  kill all in-flight fetches (used on a taken branch).
- `fetch_valid`  out  1  response strobe.
- `fetch_data`  out  DATA_W  instruction word.
- `fetch_fault`  out  2  00 ok, 01 misaligned, 10 out of range.
- `state`  out  2  00 IDLE, 01 LOAD, 10 RUN.

## Operation
**State machine (reset state is IDLE):**
- IDLE: `ld_start` → LOAD.
- LOAD: `ld_done` → RUN. `ld_start` stays in LOAD and clears the written-map again.
- RUN: `ld_start` → LOAD.
- If `ld_start` and `ld_done` are high in the same cycle, `ld_start` wins.

**Load port:**
- In LOAD, `ld_we` writes `mem[ld_addr] <= ld_data` and sets `written[ld_addr]`.
- `ld_we` is ignored in IDLE and RUN.
- A write in the same cycle as `ld_done` is still performed.

**Written-map:**
- One flop per word, cleared by reset and by `ld_start`.
- The memory array itself is not reset.

**Fetch decode** of an accepted request, with `idx = fetch_addr[ADDR_W-1:2]`:
- `fetch_addr[1:0] != 0` → fault 01, data `NOP_WORD`.
- Otherwise `idx >= DEPTH` → fault 10, data `NOP_WORD`. Upper address bits are compared, never truncated.
- Otherwise, `written[idx]` clear → fault 00, data `NOP_WORD`.
- Otherwise → fault 00, data `mem[idx]`.
- Misaligned takes priority over out-of-range.

**Pipeline:**
- LAT stages, fully pipelined: one request accepted per cycle, responses returned in order.
- A request is accepted only in RUN. Requests while `fetch_ready` = 0 are dropped with no response; the requester holds.

**Flush:**
- `flush` clears the valid bit of every in-flight stage, including the request being accepted in the same cycle.
- The next cycle's request is unaffected.

**Mode change mid-fetch:**
- Leaving RUN (on `ld_start`) flushes in-flight fetches exactly as `flush` does.

## Timing
- Reset values: `fetch_valid` 0, `fetch_data` `NOP_WORD`, `fetch_fault` 00, `state` 00, `fetch_ready` 0, written-map all 0, pipeline valids 0.
- Reset is asynchronous on assertion. Release is synchronous to the next edge.
- Latency: a request accepted at edge N gives `fetch_valid`, `fetch_data` and `fetch_fault` registered at edge N+LAT. They are valid for one cycle.
- Outputs hold `NOP_WORD` and 00 when `fetch_valid` is 0.
- Read-during-write cannot occur, because LOAD and RUN are exclusive.
- `fetch_ready` is registered from state and rises one cycle after `ld_done` is sampled. The first acceptable request is at edge D+1, where D is the `ld_done` edge.
- Throughput is one word per cycle in RUN with no bubbles.

## Test plan
- Reset then RUN without loading (`ld_start` followed immediately by `ld_done`), fetch address 0x0 → data 0x00000000, fault 00, valid exactly LAT cycles later.
- LOAD with `mem[0]` = 0x8c19003b and `mem[255]` = 0xac190064, then RUN; fetch addresses 0x0 and 0x3FC back-to-back → both words return in order on consecutive cycles, for LAT = 1 and LAT = 4.
- Fetch 0x2 → fault 01 with NOP. Fetch 0x400 (DEPTH = 256) → fault 10 with NOP. Fetch 0x1_0000_0000 truncated into ADDR_W = 32 wrap cases, e.g. 0xFFFFFFFC → fault 10.
- LAT = 3: issue fetches 0x0, 0x4, 0x8, assert `flush` with the third → no `fetch_valid` for any of the three; a fetch on the next cycle returns normally.
- In RUN with 2 fetches in flight, assert `ld_start` → no responses, `state` = 01, `fetch_ready` = 0. Previously loaded words read as NOP after `ld_done` unless rewritten.
- Assert `rst_n` low mid-pipeline → all outputs drop to their reset values immediately (asynchronously), without waiting for a clock edge.

Source files
------------

// File: rtl/imem_fetch_unit.sv
// Loadable instruction memory with a pipelined, flushable fetch port.
// Unwritten, faulted and killed fetches return NOP_WORD.
module imem_fetch_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH = 256,
    parameter int LAT = 1,
    parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000000,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic              ld_we,
    input  logic [IW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_done,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    input  logic              flush,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic [1:0]        fetch_fault,
    output logic [1:0]        state
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_LOAD = 2'b01;
    localparam logic [1:0] S_RUN  = 2'b10;

    logic [1:0] state_q, state_d;
    logic       load_en;
    logic       kill;
    logic       accept;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  written_q, written_d;

    logic              req_vld_q, req_vld_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;

    logic              vld_q [LAT];
    logic              vld_d [LAT];
    logic [DATA_W-1:0] dat_q [LAT];
    logic [DATA_W-1:0] dat_d [LAT];
    logic [1:0]        flt_q [LAT];
    logic [1:0]        flt_d [LAT];

    logic          mis;
    logic          oor;
    logic [IW-1:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ld_start)
            state_d = S_LOAD;
        else if (state_q == S_LOAD && ld_done)
            state_d = S_RUN;
    end

    always_comb begin
        load_en     = 1'b0;
        fetch_ready = 1'b0;
        unique case (1'b1)
            (state_q == S_LOAD): load_en     = 1'b1;
            (state_q == S_RUN):  fetch_ready = 1'b1;
            default: ;
        endcase
    end

    // ld_start leaves RUN, so it kills in-flight fetches like flush
    assign kill   = flush | ld_start;
    assign accept = fetch_req & fetch_ready;
    assign state  = state_q;

    always_ff @(posedge clk) begin
        if (load_en && ld_we) mem_q[ld_addr] <= ld_data;
    end

    always_comb begin
        written_d = written_q;
        if (ld_start)
            written_d = '0;
        else if (load_en && ld_we)
            written_d[ld_addr] = 1'b1;
    end

    always_comb begin
        req_vld_d  = accept & ~kill;
        req_addr_d = accept ? fetch_addr : req_addr_q;
    end

    assign mis = req_addr_q[1:0] != 2'b00;
    assign oor = |req_addr_q[ADDR_W-1:IW+2];
    assign idx = req_addr_q[IW+1:2];

    always_comb begin
        vld_d[0] = req_vld_q & ~kill;
        dat_d[0] = NOP_WORD;
        flt_d[0] = 2'b00;
        if (vld_d[0]) begin
            if (mis)                 flt_d[0] = 2'b01;
            else if (oor)            flt_d[0] = 2'b10;
            else if (written_q[idx]) dat_d[0] = mem_q[idx];
        end
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1] & ~kill;
            dat_d[i] = kill ? NOP_WORD : dat_q[i-1];
            flt_d[i] = kill ? 2'b00 : flt_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written_q  <= '0;
            req_vld_q  <= 1'b0;
            req_addr_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= NOP_WORD;
                flt_q[i] <= 2'b00;
            end
        end else begin
            written_q  <= written_d;
            req_vld_q  <= req_vld_d;
            req_addr_q <= req_addr_d;
            for (int i = 0; i < LAT; i++) begin
                vld_q[i] <= vld_d[i];
                dat_q[i] <= dat_d[i];
                flt_q[i] <= flt_d[i];
            end
        end
    end

    assign fetch_valid = vld_q[LAT-1];
    assign fetch_data  = dat_q[LAT-1];
    assign fetch_fault = flt_q[LAT-1];

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit at LAT 1, 3 and 4 sharing one stimulus.
// Each DUT gets its own monitor walking a shared expectation list.
module tb_imem_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_start, ld_we, ld_done;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;
    logic        fetch_req, flush;
    logic [31:0] fetch_addr;

    logic        vld [3];
    logic        rdy [3];
    logic [31:0] dat [3];
    logic [1:0]  flt [3];
    logic [1:0]  st  [3];

    typedef struct {
        int          acc;
        logic [31:0] d;
        logic [1:0]  f;
    } exp_t;

    exp_t exp_q [$];
    int   kills [$];
    int   ptr [3];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 4;
    endfunction

    // a kill edge anywhere from acceptance to the output edge drops it
    function automatic bit killed(int a, int l);
        foreach (kills[i])
            if (kills[i] >= a && kills[i] <= a + l) return 1'b1;
        return 1'b0;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        imem_fetch_unit #(.LAT(lat_of(k))) u_dut (
            .clk(clk), .rst_n(rst_n),
            .ld_start(ld_start), .ld_we(ld_we),
            .ld_addr(ld_addr), .ld_data(ld_data),
            .ld_done(ld_done),
            .fetch_req(fetch_req), .fetch_addr(fetch_addr),
            .fetch_ready(rdy[k]), .flush(flush),
            .fetch_valid(vld[k]), .fetch_data(dat[k]),
            .fetch_fault(flt[k]), .state(st[k])
        );

        always @(negedge clk) begin
            while (ptr[k] < exp_q.size() &&
                   (killed(exp_q[ptr[k]].acc, lat_of(k)) ||
                    exp_q[ptr[k]].acc + lat_of(k) < cyc)) begin
                if (!killed(exp_q[ptr[k]].acc, lat_of(k))) begin
                    checks++; errors++;
                    $display("FAIL missing lat%0d acc %0d",
                             lat_of(k), exp_q[ptr[k]].acc);
                end
                ptr[k]++;
            end
            checks++;
            if (vld[k]) begin
                if (ptr[k] >= exp_q.size() ||
                    exp_q[ptr[k]].acc + lat_of(k) != cyc) begin
                    errors++;
                    $display("FAIL unexpected lat%0d cyc %0d data %h",
                             lat_of(k), cyc, dat[k]);
                end else begin
                    if (dat[k] !== exp_q[ptr[k]].d ||
                        flt[k] !== exp_q[ptr[k]].f) begin
                        errors++;
                        $display("FAIL resp lat%0d got %h/%b exp %h/%b",
                                 lat_of(k), dat[k], flt[k],
                                 exp_q[ptr[k]].d, exp_q[ptr[k]].f);
                    end
                    ptr[k]++;
                end
            end else if (dat[k] !== NOP || flt[k] !== 2'b00) begin
                errors++;
                $display("FAIL idle_out lat%0d got %h/%b",
                         lat_of(k), dat[k], flt[k]);
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h exp %h", n, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string n, input logic [1:0] s,
                             input logic r);
        for (int k = 0; k < 3; k++) begin
            chk({n, "_state"}, 32'(st[k]), 32'(s));
            chk({n, "_ready"}, 32'(rdy[k]), 32'(r));
        end
    endtask

    task automatic chk_reset(input string n);
        for (int k = 0; k < 3; k++) begin
            chk({n, "_valid"}, 32'(vld[k]), 32'd0);
            chk({n, "_data"}, dat[k], NOP);
            chk({n, "_fault"}, 32'(flt[k]), 32'd0);
        end
        chk_state(n, 2'b00, 1'b0);
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] f, input bit fl);
        exp_t e;
        e.acc = cyc + 1;
        e.d = d;
        e.f = f;
        exp_q.push_back(e);
        if (fl) kills.push_back(cyc + 1);
        fetch_req = 1'b1;
        fetch_addr = a;
        flush = fl;
        step();
        fetch_req = 1'b0;
        flush = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d,
                      input bit done);
        ld_we = 1'b1;
        ld_addr = a;
        ld_data = d;
        ld_done = done;
        step();
        ld_we = 1'b0;
        ld_done = 1'b0;
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ld_start = 0; ld_we = 0; ld_done = 0;
        ld_addr = '0; ld_data = '0;
        fetch_req = 0; flush = 0; fetch_addr = '0;
        repeat (3) step();
        chk_reset("rst");
        rst_n = 1'b1;
        step();

        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;

        pulse_start();
        chk_state("load", 2'b01, 1'b0);
        ld_done = 1'b1;
        step();
        ld_done = 1'b0;
        chk_state("run", 2'b10, 1'b1);
        fetch(32'h0, NOP, 2'b00, 0);
        repeat (6) step();

        pulse_start();
        wr(8'd0, 32'h8c19003b, 0);
        wr(8'd255, 32'hac190064, 1);
        wr(8'd2, 32'h12345678, 0);
        fetch(32'h0, 32'h8c19003b, 2'b00, 0);
        fetch(32'h3FC, 32'hac190064, 2'b00, 0);
        fetch(32'h8, NOP, 2'b00, 0);
        fetch(32'h4, NOP, 2'b00, 0);
        fetch(32'h2, NOP, 2'b01, 0);
        fetch(32'h400, NOP, 2'b10, 0);
        fetch(32'hFFFFFFFC, NOP, 2'b10, 0);
        fetch(32'h3FE, NOP, 2'b01, 0);
        fetch(32'h402, NOP, 2'b01, 0);
        fetch(32'h80000000, NOP, 2'b10, 0);
        repeat (6) step();

        fetch(32'h0, 32'h8c19003b, 2'b00, 0);
        fetch(32'h4, NOP, 2'b00, 0);
        fetch(32'h8, NOP, 2'b00, 1);
        fetch(32'h3FC, 32'hac190064, 2'b00, 0);
        repeat (6) step();

        fetch(32'h0, 32'h8c19003b, 2'b00, 0);
        fetch(32'h3FC, 32'hac190064, 2'b00, 0);
        kills.push_back(cyc + 1);
        ld_start = 1'b1;
        fetch(32'h0, 32'h8c19003b, 2'b00, 0);
        ld_start = 1'b0;
        chk_state("reload", 2'b01, 1'b0);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        wr(8'd3, 32'hdeadbeef, 1);
        chk_state("rerun", 2'b10, 1'b1);
        fetch(32'h0, NOP, 2'b00, 0);
        fetch(32'h3FC, NOP, 2'b00, 0);
        fetch(32'hC, 32'hdeadbeef, 2'b00, 0);
        repeat (6) step();

        fetch(32'hC, 32'hdeadbeef, 2'b00, 0);
        fetch(32'hC, 32'hdeadbeef, 2'b00, 0);
        #2;
        kills.push_back(cyc);
        rst_n = 1'b0;
        #1;
        chk_reset("async");
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk_state("post_rst", 2'b00, 1'b0);
        repeat (3) step();

        for (int k = 0; k < 3; k++)
            chk("drained", 32'(ptr[k]), 32'(exp_q.size()));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
